// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default sizes for the data-memory arbiter
package dmem_arb_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef logic port_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with a last-winner pointer
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  port_t last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last == 1'b0) ? 2'b10 : 2'b01;
  end

  // Pointer starts at port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last <= 1'b1;
    else if (update && (gnt != 2'b00)) last <= gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port single-memory arbiter, fixed 2-cycle response latency
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rq0_valid,
  input  logic                     rq0_we,
  input  logic [ADDR_W-1:0]        rq0_addr,
  input  logic [DATA_W-1:0]        rq0_wdata,
  output logic                     rq0_ready,
  output logic                     rq0_rvalid,
  output logic [DATA_W-1:0]        rq0_rdata,
  output logic                     rq0_err,
  input  logic                     rq1_valid,
  input  logic                     rq1_we,
  input  logic [ADDR_W-1:0]        rq1_addr,
  input  logic [DATA_W-1:0]        rq1_wdata,
  output logic                     rq1_ready,
  output logic                     rq1_rvalid,
  output logic [DATA_W-1:0]        rq1_rdata,
  output logic                     rq1_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  state_t            state;
  port_t             owner;
  logic              own_we;
  logic              own_err;
  logic [1:0]        gnt;
  logic [1:0]        ready;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_bad;
  logic [DATA_W-1:0] resp_data;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({rq1_valid, rq0_valid}),
    .update (accept),
    .gnt    (gnt)
  );

  assign ready     = (state == IDLE && !reset) ? gnt : 2'b00;
  assign rq0_ready = ready[0];
  assign rq1_ready = ready[1];
  assign accept    = |ready;

  assign sel_we    = gnt[1] ? rq1_we    : rq0_we;
  assign sel_addr  = gnt[1] ? rq1_addr  : rq0_addr;
  assign sel_wdata = gnt[1] ? rq1_wdata : rq0_wdata;
  assign sel_bad   = (sel_addr[1:0] != 2'b00) ||
                     ({2'b00, sel_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH));

  // Memory strobe is registered at acceptance so it lands exactly in ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      own_we    <= 1'b0;
      own_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner   <= gnt[1];
            own_we  <= sel_we;
            own_err <= sel_bad;
            mem_en  <= !sel_bad;
            mem_we  <= sel_we && !sel_bad;
            if (!sel_bad) begin
              mem_addr  <= sel_addr[AW+1:2];
              mem_wdata <= sel_wdata;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data comes straight from the synchronous memory output during RESP.
  assign resp_data  = (own_we || own_err) ? '0 : mem_rdata;
  assign rq0_rvalid = (state == RESP) && (owner == 1'b0);
  assign rq1_rvalid = (state == RESP) && (owner == 1'b1);
  assign rq0_rdata  = rq0_rvalid ? resp_data : '0;
  assign rq1_rdata  = rq1_rvalid ? resp_data : '0;
  assign rq0_err    = rq0_rvalid && own_err;
  assign rq1_err    = rq1_rvalid && own_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  logic        clk;
  logic        reset;
  logic        rq0_valid, rq0_we, rq0_ready, rq0_rvalid, rq0_err;
  logic [31:0] rq0_addr, rq0_wdata, rq0_rdata;
  logic        rq1_valid, rq1_we, rq1_ready, rq1_rvalid, rq1_err;
  logic [31:0] rq1_addr, rq1_wdata, rq1_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int gseq[$];
  int cnt0, cnt1, both_ready;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_ready(rq0_ready), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata), .rq0_err(rq0_err),
    .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_ready(rq1_ready), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata), .rq1_err(rq1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[2] = 32'h14;
    mem_rdata = 32'h0;
    reset = 1'b1;
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 32'h8;  rq0_wdata = 32'h0;
    rq1_valid = 1'b0; rq1_we = 1'b0; rq1_addr = 32'h0;  rq1_wdata = 32'h0;

    // Reset state
    next(); probe();
    check("rst_ready0", 32'(rq0_ready), 32'd0);
    check("rst_ready1", 32'(rq1_ready), 32'd0);
    check("rst_rvalid0", 32'(rq0_rvalid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata0", rq0_rdata, 32'd0);
    check("rst_err1", 32'(rq1_err), 32'd0);

    // Single read, granted in the first IDLE cycle
    next(); reset = 1'b0;
    probe();
    check("rd_ready0_N", 32'(rq0_ready), 32'd1);
    check("rd_ready1_N", 32'(rq1_ready), 32'd0);
    check("rd_mem_en_N", 32'(mem_en), 32'd0);
    next(); rq0_valid = 1'b0;
    probe();
    check("rd_mem_en_N1", 32'(mem_en), 32'd1);
    check("rd_mem_we_N1", 32'(mem_we), 32'd0);
    check("rd_mem_addr_N1", 32'(mem_addr), 32'd2);
    check("rd_ready0_N1", 32'(rq0_ready), 32'd0);
    next(); probe();
    check("rd_rvalid0_N2", 32'(rq0_rvalid), 32'd1);
    check("rd_rdata0_N2", rq0_rdata, 32'h14);
    check("rd_err0_N2", 32'(rq0_err), 32'd0);
    check("rd_mem_en_N2", 32'(mem_en), 32'd0);
    next(); probe();
    check("rd_rvalid0_N3", 32'(rq0_rvalid), 32'd0);
    check("rd_rdata0_N3", rq0_rdata, 32'd0);

    // Contention from reset
    reset = 1'b1;
    rq0_valid = 1'b1; rq0_we = 1'b1; rq0_addr = 32'h10; rq0_wdata = 32'hAA;
    rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 32'h10;
    next(); reset = 1'b0;
    probe();
    check("ct_ready0_N", 32'(rq0_ready), 32'd1);
    check("ct_ready1_N", 32'(rq1_ready), 32'd0);
    next(); rq0_valid = 1'b0;
    probe();
    check("ct_mem_en_N1", 32'(mem_en), 32'd1);
    check("ct_mem_we_N1", 32'(mem_we), 32'd1);
    check("ct_mem_addr_N1", 32'(mem_addr), 32'd4);
    check("ct_mem_wdata_N1", mem_wdata, 32'hAA);
    check("ct_ready1_N1", 32'(rq1_ready), 32'd0);
    next(); probe();
    check("ct_rvalid0_N2", 32'(rq0_rvalid), 32'd1);
    check("ct_rdata0_N2", rq0_rdata, 32'd0);
    check("ct_rvalid1_N2", 32'(rq1_rvalid), 32'd0);
    next(); probe();
    check("ct_ready1_N3", 32'(rq1_ready), 32'd1);
    next(); rq1_valid = 1'b0;
    probe();
    check("ct_mem_en_N4", 32'(mem_en), 32'd1);
    check("ct_mem_we_N4", 32'(mem_we), 32'd0);
    next(); probe();
    check("ct_rvalid1_N5", 32'(rq1_rvalid), 32'd1);
    check("ct_rdata1_N5", rq1_rdata, 32'hAA);

    // Fairness: both ports valid for 12 cycles
    next();
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 32'h8;
    rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 32'h10;
    cnt0 = 0; cnt1 = 0; both_ready = 0;
    for (int i = 0; i < 12; i++) begin
      probe();
      if (rq0_ready && rq1_ready) both_ready++;
      if (rq0_ready) gseq.push_back(0);
      if (rq1_ready) gseq.push_back(1);
      if (rq0_rvalid) begin
        cnt0++;
        check("fr_rdata0", rq0_rdata, 32'h14);
      end
      if (rq1_rvalid) begin
        cnt1++;
        check("fr_rdata1", rq1_rdata, 32'hAA);
      end
      next();
    end
    check("fr_grants", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("fr_order", (i < gseq.size()) ? 32'(gseq[i]) : 32'hFFFF_FFFF, 32'(i % 2));
    check("fr_resp0", 32'(cnt0), 32'd2);
    check("fr_resp1", 32'(cnt1), 32'd2);
    check("fr_both_ready", 32'(both_ready), 32'd0);

    // Errors: misaligned then out of range
    rq0_valid = 1'b0;
    rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 32'h6;
    probe();
    check("er_ready1_N", 32'(rq1_ready), 32'd1);
    next(); rq1_addr = 32'd1024;
    probe();
    check("er_mem_en_N1", 32'(mem_en), 32'd0);
    check("er_ready1_N1", 32'(rq1_ready), 32'd0);
    next(); probe();
    check("er_rvalid1_N2", 32'(rq1_rvalid), 32'd1);
    check("er_err1_N2", 32'(rq1_err), 32'd1);
    check("er_rdata1_N2", rq1_rdata, 32'd0);
    check("er_rvalid0_N2", 32'(rq0_rvalid), 32'd0);
    check("er_err0_N2", 32'(rq0_err), 32'd0);
    next(); probe();
    check("oor_ready1_N", 32'(rq1_ready), 32'd1);
    next(); rq1_valid = 1'b0;
    probe();
    check("oor_mem_en_N1", 32'(mem_en), 32'd0);
    next(); probe();
    check("oor_rvalid1_N2", 32'(rq1_rvalid), 32'd1);
    check("oor_err1_N2", 32'(rq1_err), 32'd1);
    check("oor_rdata1_N2", rq1_rdata, 32'd0);

    // Write ack then read-back
    next();
    rq1_valid = 1'b1; rq1_we = 1'b1; rq1_addr = 32'h0; rq1_wdata = 32'h5;
    probe();
    check("wr_ready1_N", 32'(rq1_ready), 32'd1);
    next(); rq1_we = 1'b0; rq1_wdata = 32'h0;
    probe();
    check("wr_mem_en_N1", 32'(mem_en), 32'd1);
    check("wr_mem_we_N1", 32'(mem_we), 32'd1);
    check("wr_mem_addr_N1", 32'(mem_addr), 32'd0);
    check("wr_mem_wdata_N1", mem_wdata, 32'h5);
    next(); probe();
    check("wr_rvalid1_N2", 32'(rq1_rvalid), 32'd1);
    check("wr_err1_N2", 32'(rq1_err), 32'd0);
    check("wr_rdata1_N2", rq1_rdata, 32'd0);
    next(); probe();
    check("rb_ready1_N", 32'(rq1_ready), 32'd1);
    next(); rq1_valid = 1'b0;
    probe();
    check("rb_mem_we_N1", 32'(mem_we), 32'd0);
    next(); probe();
    check("rb_rvalid1_N2", 32'(rq1_rvalid), 32'd1);
    check("rb_rdata1_N2", rq1_rdata, 32'h5);

    // Reset asserted during ISSUE
    next();
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 32'h8;
    probe();
    check("rm_ready0_N", 32'(rq0_ready), 32'd1);
    next(); rq0_valid = 1'b0; reset = 1'b1;
    probe();
    check("rm_mem_en", 32'(mem_en), 32'd0);
    check("rm_rvalid0", 32'(rq0_rvalid), 32'd0);
    check("rm_ready0", 32'(rq0_ready), 32'd0);
    next(); probe();
    check("rm_rvalid0_late", 32'(rq0_rvalid), 32'd0);
    next(); reset = 1'b0;
    rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 32'h8;
    probe();
    check("rm_ready1_first", 32'(rq1_ready), 32'd1);
    check("rm_ready0_first", 32'(rq0_ready), 32'd0);
    next(); rq1_valid = 1'b0;
    probe();
    check("rm_mem_en_N1", 32'(mem_en), 32'd1);
    check("rm_mem_addr_N1", 32'(mem_addr), 32'd2);
    next(); probe();
    check("rm_rvalid1_N2", 32'(rq1_rvalid), 32'd1);
    check("rm_rdata1_N2", rq1_rdata, 32'h14);
    check("rm_rvalid0_N2", 32'(rq0_rvalid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter DEPTH, default 256, memory size in words.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rq0_valid / rq1_valid  input  1  requester 0 (core load/store) / requester 1 (debug loader) request present.
REQ-007 rqN_we  input  1  1 = write, 0 = read.
REQ-008 rqN_addr  input  ADDR_W  byte address.
REQ-009 rqN_wdata  input  DATA_W  write data.
REQ-010 rqN_ready  output  1  request accepted this cycle when valid && ready.
REQ-011 rqN_rvalid  output  1  one-cycle response pulse.
REQ-012 rqN_rdata  output  DATA_W  read data, qualified by rqN_rvalid.
REQ-013 rqN_err  output  1  error flag, qualified by rqN_rvalid.
REQ-014 mem_en  output  1  memory access strobe.
REQ-015 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-016 mem_addr  output  $clog2(DEPTH)  word index.
REQ-017 mem_wdata  output  DATA_W  memory write data.
REQ-018 mem_rdata  input  DATA_W  synchronous-read data, valid the cycle after mem_en.

Function
REQ-019 FSM states: IDLE, ISSUE, RESP.
REQ-020 rqN_ready SHALL be high only in IDLE and only for the granted port; at most one ready per cycle.
REQ-021 Grant in IDLE: a single valid port wins; if both are valid, the port not granted last wins (round-robin).
REQ-022 Acceptance at cycle N SHALL register port, we, addr, and wdata; the FSM moves IDLE -> ISSUE.
REQ-023 ISSUE (cycle N+1): for a legal request, mem_en = 1 for exactly one cycle, with mem_we, mem_addr = addr[ADDR_W-1:2], and mem_wdata driven; then -> RESP.
REQ-024 RESP (cycle N+2): owning port rqN_rvalid = 1 for one cycle; reads return rdata = mem_rdata; writes return rdata = 0; then -> IDLE.
REQ-025 Fixed latency from acceptance to rvalid SHALL be 2 cycles; maximum throughput is one request per 3 cycles.
REQ-026 Illegal request means addr[1:0] != 0 or addr[ADDR_W-1:2] >= DEPTH; mem_en SHALL stay 0, and at N+2 rvalid = 1, err = 1, rdata = 0.
REQ-027 Priority pointer SHALL update only on acceptance, including illegal requests.
REQ-028 Requests arriving in ISSUE/RESP SHALL wait (ready = 0); requesters hold valid and payload until accepted.
REQ-029 rqN_err = 0 whenever rqN_rvalid = 0; rdata SHALL be 0 when rvalid = 0.

Reset
REQ-030 On reset: state = IDLE; all ready/rvalid/err/mem_en/mem_we = 0; mem_addr, mem_wdata, rdata = 0; priority pointer favours port 0.
REQ-031 Reset during ISSUE or RESP SHALL abort the transaction with no rvalid and no further mem_en; a write already strobed is not undone.
REQ-032 The first grant after reset deassertion can occur in the first IDLE cycle.

Structure
REQ-033 Package dmem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, RESP), the port-index typedef, and the default DATA_W/ADDR_W/DEPTH constants.
REQ-034 A sub-module rr_arbiter2 SHALL implement the 2-way round-robin grant (inputs req[1:0], update, clk, reset; output gnt[1:0], one-hot or zero).

Verification
REQ-035 Single read: rq0 read addr 0x8 with memory word 2 = 0x14 -> ready at N, mem_en/mem_addr = 2 at N+1, rq0_rvalid, rdata = 0x14 at N+2.
REQ-036 Contention: both valid from reset, rq0 write 0x10 <- 0xAA, rq1 read 0x10 -> rq0 served first; rq1 accepted at N+3 and returns 0xAA at N+5.
REQ-037 Fairness: both ports continuously valid for 12 cycles -> grants alternate 0, 1, 0, 1; each port gets exactly 2 responses.
REQ-038 Errors: rq1 read addr 0x6 (misaligned) and addr 4*DEPTH (out of range) -> no mem_en, rq1_rvalid = 1, err = 1, rdata = 0 at N+2 for each.
REQ-039 Reset mid-op: reset asserted in ISSUE -> outputs 0 at once, no rvalid; after release, rq1 alone is granted on the first IDLE cycle.
REQ-040 Write ack: rq1 write 0x0 <- 0x5 -> mem_we = 1 at N+1, rq1_rvalid = 1, err = 0, rdata = 0 at N+2; a subsequent read returns 0x5.
